// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, font geometry, FSM states and font table contents
package lcd_pkg;
  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;
  localparam int unsigned W16 = 8;
  localparam int unsigned H16 = 16;
  localparam int unsigned W12 = 6;
  localparam int unsigned H12 = 12;
  typedef enum logic [2:0] {IDLE, CMD, ROM_RD, PIX, DONE} state_t;
  function automatic logic [8:0] cmd_word(input logic [3:0] idx, input logic [7:0] caset, input logic [7:0] raset,
                                          input logic [7:0] ramwr, input logic [8:0] xs, input logic [8:0] xe,
                                          input logic [8:0] ys, input logic [8:0] ye);
    case (idx)
      4'd0:    cmd_word = {1'b0, caset};
      4'd1:    cmd_word = {1'b1, 7'd0, xs[8]};
      4'd2:    cmd_word = {1'b1, xs[7:0]};
      4'd3:    cmd_word = {1'b1, 7'd0, xe[8]};
      4'd4:    cmd_word = {1'b1, xe[7:0]};
      4'd5:    cmd_word = {1'b0, raset};
      4'd6:    cmd_word = {1'b1, 7'd0, ys[8]};
      4'd7:    cmd_word = {1'b1, ys[7:0]};
      4'd8:    cmd_word = {1'b1, 7'd0, ye[8]};
      4'd9:    cmd_word = {1'b1, ye[7:0]};
      default: cmd_word = {1'b0, ramwr};
    endcase
  endfunction
  // Synthetic glyph sets: framed top/bottom rows for 8x16, 6-bit-wide rows (bits 7:2) for 6x12
  function automatic logic [7:0] font16(input logic [6:0] c, input logic [3:0] r);
    font16 = r == 4'd0 ? 8'h81 : r == 4'd15 ? 8'hFF : {c, 1'b0} ^ {r, r};
  endfunction
  function automatic logic [7:0] font12(input logic [6:0] c, input logic [3:0] r);
    font12 = r >= 4'd12 ? 8'h00 : r == 4'd0 ? 8'h84 : ({c, 1'b0} ^ {r, r}) & 8'hFC;
  endfunction
endpackage

// File: rtl/lcd_font_rom.sv
// lcd_font_rom: 1-cycle-latency glyph ROM holding the 8x16 and 6x12 tables
module lcd_font_rom
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       big_i,
  input  logic [6:0] char_i,
  input  logic [3:0] row_i,
  output logic [7:0] data_o
);
  always_ff @(posedge clk_i) data_o <= big_i ? font16(char_i, row_i) : font12(char_i, row_i);
endmodule

// File: rtl/lcd_show_char.sv
// lcd_show_char: sets the LCD window for one glyph and streams it as RGB565 words
module lcd_show_char
  import lcd_pkg::*;
#(
  parameter logic [15:0] FG_COLOR  = 16'hFFFF,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter logic [7:0]  CMD_CASET = CASET,
  parameter logic [7:0]  CMD_RASET = RASET,
  parameter logic [7:0]  CMD_RAMWR = RAMWR
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       init_done,
  input  logic       show_char_flag,
  input  logic [6:0] ascii_num,
  input  logic [8:0] start_x,
  input  logic [8:0] start_y,
  input  logic       en_size,
  input  logic       wr_done,
  output logic       show_char_wr_en,
  output logic [8:0] show_char_data,
  output logic       show_char_busy,
  output logic       show_char_done
);
  state_t state_q, state_d;
  logic [6:0] ascii_q, ascii_d;
  logic [8:0] xs_q, xs_d, ys_q, ys_d;
  logic big_q, big_d, lo_q, lo_d, pend_q, pend_d, rd_q, rd_d;
  logic [3:0] idx_q, idx_d, row_q, row_d, col_q, col_d;
  logic [7:0] bits_q, bits_d, rom_data;
  logic [3:0] w, h_last;
  logic [8:0] xe, ye;
  logic [15:0] color;
  logic issue, ack, last_col;
  lcd_font_rom u_rom (.clk_i(sys_clk), .big_i(big_q), .char_i(ascii_q), .row_i(row_q), .data_o(rom_data));
  assign w        = big_q ? 4'(W16) : 4'(W12);
  assign h_last   = big_q ? 4'(H16 - 1) : 4'(H12 - 1);
  assign xe       = xs_q + 9'(w) - 9'd1;
  assign ye       = ys_q + (big_q ? 9'(H16) : 9'(H12)) - 9'd1;
  assign issue    = (state_q == CMD || state_q == PIX) && !pend_q;
  assign ack      = pend_q && wr_done;
  assign last_col = col_q == w - 4'd1;
  assign color    = bits_q[3'd7 - col_q[2:0]] ? FG_COLOR : BG_COLOR;
  assign show_char_wr_en = issue;
  assign show_char_busy  = state_q == CMD || state_q == ROM_RD || state_q == PIX;
  assign show_char_done  = state_q == DONE;
  assign show_char_data  = state_q == CMD ? cmd_word(idx_q, CMD_CASET, CMD_RASET, CMD_RAMWR, xs_q, xe, ys_q, ye)
                         : state_q == PIX ? {1'b1, lo_q ? color[7:0] : color[15:8]} : 9'd0;
  always_comb begin
    state_d = state_q;
    ascii_d = ascii_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    big_d   = big_q;
    lo_d    = lo_q;
    pend_d  = issue ? 1'b1 : ack ? 1'b0 : pend_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    bits_d  = bits_q;
    case (state_q)
      IDLE: if (show_char_flag && init_done) begin
        state_d = CMD;
        ascii_d = ascii_num;
        xs_d    = start_x;
        ys_d    = start_y;
        big_d   = en_size;
        {idx_d, row_d, col_d, lo_d, pend_d, rd_d} = '0;
      end
      CMD: if (ack) begin
        idx_d   = idx_q + 4'd1;
        state_d = idx_q == 4'd10 ? ROM_RD : CMD;
      end
      // first cycle lets the ROM register the new row, second captures it
      ROM_RD: begin
        rd_d    = !rd_q;
        bits_d  = rd_q ? rom_data : bits_q;
        state_d = rd_q ? PIX : ROM_RD;
      end
      PIX: if (ack) begin
        lo_d = !lo_q;
        if (lo_q) begin
          col_d = last_col ? 4'd0 : col_q + 4'd1;
          row_d = last_col ? row_q + 4'd1 : row_q;
          state_d = !last_col ? PIX : row_q == h_last ? DONE : ROM_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ascii_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      {big_q, lo_q, pend_q, rd_q} <= '0;
      {idx_q, row_q, col_q} <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      ascii_q <= ascii_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      {big_q, lo_q, pend_q, rd_q} <= {big_d, lo_d, pend_d, rd_d};
      {idx_q, row_q, col_q} <= {idx_d, row_d, col_d};
      bits_q  <= bits_d;
    end
  end
endmodule

// File: tb/tb_lcd_show_char.sv
// tb_lcd_show_char: table-driven and randomized checks against a word-list reference model
module tb_lcd_show_char;
  logic clk = 0, rst_n = 0, init_done = 0, flag = 0, en_size = 0, wr_done = 0;
  logic [6:0] ascii = 0;
  logic [8:0] sx = 0, sy = 0;
  logic wr_en, busy, done;
  logic [8:0] data;
  int checks = 0, errors = 0, done_cnt = 0, lat = 2;
  bit auto_ack = 1, rand_lat = 0;
  int cap[$], expq[$];
  typedef struct {int a, x, y, big, cnt, xe_hi, xe_lo, ye_hi, ye_lo;} vec_t;
  vec_t tv[5];
  int first11[11] = '{'h02A, 'h100, 'h148, 'h100, 'h14F, 'h02B, 'h100, 'h110, 'h100, 'h11F, 'h02C};

  lcd_show_char dut (.sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done), .show_char_flag(flag),
    .ascii_num(ascii), .start_x(sx), .start_y(sy), .en_size(en_size), .wr_done(wr_done),
    .show_char_wr_en(wr_en), .show_char_data(data), .show_char_busy(busy), .show_char_done(done));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) cap.push_back(int'(data));
    if (done) done_cnt++;
  end

  initial begin
    int l;
    forever begin
      @(negedge clk);
      if (wr_en && auto_ack) begin
        l = rand_lat ? int'($urandom_range(1, 4)) : lat;
        repeat (l) @(posedge clk);
        #1 wr_done = 1;
        @(posedge clk);
        #1 wr_done = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int glyph(int big, int c, int r);
    int base = ((c * 2) ^ (r * 17)) & 255;
    if (big != 0) return r == 0 ? 129 : r == 15 ? 255 : base;
    return r == 0 ? 132 : base & 252;
  endfunction

  task automatic build_exp(input int a, input int x, input int y, input int big);
    int w = big != 0 ? 8 : 6, h = big != 0 ? 16 : 12;
    int xe = (x + w - 1) % 512, ye = (y + h - 1) % 512, c;
    expq = {'h2A, 256 | (x >> 8), 256 | (x & 255), 256 | (xe >> 8), 256 | (xe & 255),
            'h2B, 256 | (y >> 8), 256 | (y & 255), 256 | (ye >> 8), 256 | (ye & 255), 'h2C};
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
        c = ((glyph(big, a, r) >> (7 - k)) & 1) != 0 ? 'hFFFF : 'h0000;
        expq.push_back(256 | (c >> 8));
        expq.push_back(256 | (c & 255));
      end
  endtask

  task automatic start_req(input int a, input int x, input int y, input int big);
    ascii = 7'(a); sx = 9'(x); sy = 9'(y); en_size = big[0];
    @(posedge clk); #1 flag = 1;
    @(posedge clk); #1 flag = 0;
  endtask

  task automatic wait_done_cnt(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 20000) begin @(posedge clk); n++; end
    chk({name, " done_seen"}, done_cnt == d0 ? 0 : 1, 1);
  endtask

  task automatic wait_done_neg(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20000);
    chk({name, " done_pulse"}, int'(done), 1);
  endtask

  task automatic cmp_words(input string name);
    chk({name, " count"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      chk($sformatf("%s word%0d", name, i), cap[i], expq[i]);
      if (cap[i] != expq[i]) break;
    end
  endtask

  task automatic run_char(input int a, input int x, input int y, input int big, input string name);
    int d0 = done_cnt;
    build_exp(a, x, y, big);
    cap.delete();
    start_req(a, x, y, big);
    chk({name, " busy"}, int'(busy), 1);
    wait_done_cnt(d0, name);
    repeat (4) @(posedge clk);
    #1 chk({name, " one_done"}, done_cnt - d0, 1);
    cmp_words(name);
  endtask

  initial begin
    int d0, n;
    tv[0] = '{82, 72, 16, 1, 267, 'h100, 'h14F, 'h100, 'h11F};
    tv[1] = '{82, 8, 48, 0, 155, 'h100, 'h10D, 'h100, 'h13B};
    tv[2] = '{0, 508, 505, 1, 267, 'h100, 'h103, 'h100, 'h108};
    tv[3] = '{127, 507, 510, 0, 155, 'h100, 'h100, 'h100, 'h109};
    tv[4] = '{65, 300, 400, 1, 267, 'h101, 'h133, 'h101, 'h19F};
    init_done = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst data", int'(data), 0);
    rst_n = 1;

    for (int i = 0; i < 5; i++) begin
      run_char(tv[i].a, tv[i].x, tv[i].y, tv[i].big, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d total", i), cap.size(), tv[i].cnt);
      chk($sformatf("vec%0d xe_hi", i), cap[3], tv[i].xe_hi);
      chk($sformatf("vec%0d xe_lo", i), cap[4], tv[i].xe_lo);
      chk($sformatf("vec%0d ye_hi", i), cap[8], tv[i].ye_hi);
      chk($sformatf("vec%0d ye_lo", i), cap[9], tv[i].ye_lo);
      if (i == 0) begin
        for (int k = 0; k < 11; k++) chk($sformatf("hdr%0d", k), cap[k], first11[k]);
        for (int k = 0; k < 16; k++) chk($sformatf("row81 w%0d", k), cap[11 + k], (k < 2 || k > 13) ? 'h1FF : 'h100);
      end
    end

    rand_lat = 1;
    for (int i = 0; i < 6; i++)
      run_char(int'($urandom_range(0, 127)), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    rand_lat = 0;

    build_exp(82, 72, 16, 1);
    cap.delete();
    d0 = done_cnt;
    start_req(82, 72, 16, 1);
    repeat (150) @(posedge clk);
    start_req(5, 0, 0, 0);
    wait_done_neg("repulse");
    flag = 1;
    @(posedge clk); #1 flag = 0;
    chk("done-cycle flag busy", int'(busy), 0);
    repeat (6) @(posedge clk);
    #1 chk("done-cycle flag no wr", int'(wr_en), 0);
    chk("repulse one_done", done_cnt - d0, 1);
    cmp_words("repulse");

    d0 = done_cnt;
    start_req(3, 40, 40, 0);
    wait_done_neg("next");
    @(posedge clk); #1 flag = 1;
    @(posedge clk); #1 flag = 0;
    chk("cycle-after flag busy", int'(busy), 1);
    wait_done_cnt(d0 + 1, "cycle-after");
    repeat (4) @(posedge clk);

    cap.delete();
    d0 = done_cnt;
    start_req(82, 72, 16, 1);
    n = 0;
    while (cap.size() < 40 && n < 5000) begin @(posedge clk); n++; end
    chk("reach pix", cap.size() >= 40 ? 1 : 0, 1);
    #1 rst_n = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst wr_en", int'(wr_en), 0);
    rst_n = 1;
    repeat (5) @(posedge clk);
    chk("abort no done", done_cnt - d0, 0);
    run_char(10, 20, 30, 0, "after_rst");

    init_done = 0;
    cap.delete();
    start_req(82, 72, 16, 1);
    n = 0;
    repeat (10) begin @(negedge clk); n += int'(busy); end
    chk("no init busy", n, 0);
    chk("no init wr", cap.size(), 0);
    init_done = 1;

    auto_ack = 0;
    build_exp(33, 100, 100, 1);
    cap.delete();
    d0 = done_cnt;
    start_req(33, 100, 100, 1);
    n = 0;
    while (cap.size() == 0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    repeat (50) begin @(negedge clk); n += int'(wr_en); end
    chk("hold no wr_en", n, 0);
    chk("hold data", int'(data), 'h02A);
    chk("hold words", cap.size(), 1);
    @(posedge clk); #1 wr_done = 1;
    @(posedge clk); #1 wr_done = 0;
    auto_ack = 1;
    wait_done_cnt(d0, "hold");
    repeat (4) @(posedge clk);
    cmp_words("hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
